// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell, LSB first, start/busy/done handshake.
// Optional macro SERIAL_SUB_SIGNED_OVF_EN adds a registered two's-complement overflow output.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    output logic             ovf,
`endif
    output logic             borrow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CW-1:0]    bit_cnt;
    logic             borrow_q;
    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             bout;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    // Operand sign bits are kept because the shift registers lose them during RUN.
    logic             a_msb;
    logic             b_msb;
`endif

    assign a_bit = a_sr[0];
    assign b_bit = b_sr[0];
    assign d_bit = a_bit ^ b_bit ^ borrow_q;
    assign bout  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_q);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            bit_cnt  <= '0;
            borrow_q <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            diff     <= '0;
            borrow   <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            ovf      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr     <= minuend;
                        b_sr     <= subtrahend;
                        borrow_q <= 1'b0;
                        bit_cnt  <= '0;
                        busy     <= 1'b1;
                        state    <= RUN;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                        a_msb    <= minuend[WIDTH-1];
                        b_msb    <= subtrahend[WIDTH-1];
`endif
                    end
                end
                RUN: begin
                    a_sr     <= a_sr >> 1;
                    b_sr     <= b_sr >> 1;
                    res_sr   <= {d_bit, res_sr[WIDTH-1:1]};
                    borrow_q <= bout;
                    bit_cnt  <= bit_cnt + 1'b1;
                    if (bit_cnt == CW'(WIDTH - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    diff   <= res_sr;
                    borrow <= borrow_q;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                    ovf    <= (a_msb != b_msb) && (res_sr[WIDTH-1] != a_msb);
`endif
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): vector table plus handshake,
// back-to-back, dropped-start and asynchronous-reset sequences.
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             sys_clk;
    logic             sys_rst;
    logic             start;
    logic [WIDTH-1:0] minuend;
    logic [WIDTH-1:0] subtrahend;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic             ovf;
`endif

    int tests_run;
    int tests_failed;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_diff;
        logic       exp_borrow;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [11];

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .start      (start),
        .minuend    (minuend),
        .subtrahend (subtrahend),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        .ovf        (ovf),
`endif
        .borrow     (borrow)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Samples 1 time unit after each rising edge until done or the budget runs out.
    task automatic wait_done(output int lat, output bit found);
        found = 1'b0;
        lat   = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge sys_clk);
            #1;
            lat++;
            if (done === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) check_output("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b, input string tag);
        int lat;
        bit found;
        logic [7:0] got_diff;
        @(negedge sys_clk);
        start      = 1'b1;
        minuend    = a;
        subtrahend = b;
        @(posedge sys_clk);
        #1;
        check_output({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
        @(negedge sys_clk);
        start      = 1'b0;
        minuend    = 8'($urandom);
        subtrahend = 8'($urandom);
        wait_done(lat, found);
        if (found) begin
            check_output({tag, "_latency"}, 32'(lat), 32'(WIDTH + 1));
            check_output({tag, "_busy_at_done"}, 32'(busy), 32'd0);
            got_diff = diff;
            @(posedge sys_clk);
            #1;
            check_output({tag, "_done_width"}, 32'(done), 32'd0);
            check_output({tag, "_diff_held"}, 32'(diff), 32'(got_diff));
        end
    endtask

    initial begin
        int lat;
        bit found;
        int ndone;
        int busy_low;
        int busy_high;
        int edge_idx;
        int done_at [3];

        tests_run    = 0;
        tests_failed = 0;

        vecs[0]  = '{8'd200, 8'd55,  8'd145, 1'b0, 1'b0};
        vecs[1]  = '{8'd5,   8'd9,   8'd252, 1'b1, 1'b0};
        vecs[2]  = '{8'hAA,  8'hAA,  8'd0,   1'b0, 1'b0};
        vecs[3]  = '{8'd0,   8'd0,   8'd0,   1'b0, 1'b0};
        vecs[4]  = '{8'd255, 8'd0,   8'd255, 1'b0, 1'b0};
        vecs[5]  = '{8'd0,   8'd255, 8'd1,   1'b1, 1'b0};
        vecs[6]  = '{8'd100, 8'd1,   8'd99,  1'b0, 1'b0};
        vecs[7]  = '{8'h80,  8'h01,  8'h7F,  1'b0, 1'b1};
        vecs[8]  = '{8'h10,  8'h01,  8'h0F,  1'b0, 1'b0};
        vecs[9]  = '{8'h7F,  8'hFF,  8'h80,  1'b1, 1'b1};
        vecs[10] = '{8'd3,   8'd1,   8'd2,   1'b0, 1'b0};

        sys_rst    = 1'b1;
        start      = 1'b0;
        minuend    = '0;
        subtrahend = '0;
        #12;
        check_output("reset_busy",   32'(busy),   32'd0);
        check_output("reset_done",   32'(done),   32'd0);
        check_output("reset_diff",   32'(diff),   32'd0);
        check_output("reset_borrow", 32'(borrow), 32'd0);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
        check_output("reset_ovf",    32'(ovf),    32'd0);
`endif
        @(negedge sys_clk);
        sys_rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            apply_stimulus(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
            check_output($sformatf("vec%0d_diff", i),   32'(diff),   32'(vecs[i].exp_diff));
            check_output($sformatf("vec%0d_borrow", i), 32'(borrow), 32'(vecs[i].exp_borrow));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            check_output($sformatf("vec%0d_ovf", i),    32'(ovf),    32'(vecs[i].exp_ovf));
`endif
        end

        // A start pulsed mid-run must be dropped: one result, no second done.
        @(negedge sys_clk);
        start = 1'b1; minuend = 8'd3; subtrahend = 8'd1;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        start = 1'b1; minuend = 8'd9; subtrahend = 8'd9;
        @(negedge sys_clk);
        start = 1'b0;
        wait_done(lat, found);
        check_output("drop_diff",   32'(diff),   32'd2);
        check_output("drop_borrow", 32'(borrow), 32'd0);
        ndone = 0;
        busy_high = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge sys_clk);
            #1;
            if (done === 1'b1) ndone++;
            if (busy === 1'b1) busy_high++;
        end
        check_output("drop_extra_done", 32'(ndone),     32'd0);
        check_output("drop_busy_idle",  32'(busy_high), 32'd0);

        // Start held high: done every WIDTH+2 cycles, busy low for one sample between runs.
        @(negedge sys_clk);
        start = 1'b1; minuend = 8'd200; subtrahend = 8'd55;
        ndone = 0;
        busy_low = 0;
        edge_idx = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge sys_clk);
            #1;
            edge_idx++;
            if (done === 1'b1) begin
                done_at[ndone] = edge_idx;
                ndone++;
                check_output($sformatf("b2b_diff%0d", ndone), 32'(diff), 32'd145);
                if (ndone == 3) break;
            end
            if (ndone == 1 && busy === 1'b0) busy_low++;
        end
        @(negedge sys_clk);
        start = 1'b0;
        check_output("b2b_done_count", 32'(ndone), 32'd3);
        if (ndone == 3) begin
            check_output("b2b_gap1", 32'(done_at[1] - done_at[0]), 32'(WIDTH + 2));
            check_output("b2b_gap2", 32'(done_at[2] - done_at[1]), 32'(WIDTH + 2));
        end
        check_output("b2b_busy_low", 32'(busy_low), 32'd1);
        repeat (2) @(posedge sys_clk);

        // Reset mid-operation clears outputs without a clock edge.
        @(negedge sys_clk);
        start = 1'b1; minuend = 8'd100; subtrahend = 8'd1;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (4) @(posedge sys_clk);
        #2;
        sys_rst = 1'b1;
        #1;
        check_output("arst_busy",   32'(busy),   32'd0);
        check_output("arst_done",   32'(done),   32'd0);
        check_output("arst_diff",   32'(diff),   32'd0);
        check_output("arst_borrow", 32'(borrow), 32'd0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        apply_stimulus(8'd100, 8'd1, "post_rst");
        check_output("post_rst_diff",   32'(diff),   32'd99);
        check_output("post_rst_borrow", 32'(borrow), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
